bp_pht_update_ctrl: RTL

- Write-port controller for one pattern history table (PHT) in the branch predictor.
- Accepts three update sources each cycle: the corrected-result update, the ID-stage rollback and the EX-stage rollback.
- Queues the updates and serialises them into read-modify-write (RMW) operations on the table's single write port, with saturating counter arithmetic.
- Also sequences table initialisation after reset. Sits between the pipeline control signals and one PHT RAM instance.

---
 rtl/bp_pht_update_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/bp_pht_update_ctrl.sv
// Write-port controller for one PHT: queues update/rollback requests and serialises saturating RMWs.
// Optional BP_PHT_UPD_STATS_EN adds drop_cnt/op_cnt statistics outputs.
`timescale 1ns/1ps
module bp_pht_update_ctrl #(
   parameter int unsigned INDEX_WIDTH = 10,
   parameter int unsigned CNT_WIDTH   = 2,
   parameter int unsigned CNT_INIT    = 0,
   parameter int unsigned QUEUE_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   upd_en,
   input  logic [INDEX_WIDTH-1:0] upd_index,
   input  logic                   upd_taken,
   input  logic                   rb_id_en,
   input  logic [INDEX_WIDTH-1:0] rb_id_index,
   input  logic                   rb_id_taken,
   input  logic                   rb_ex_en,
   input  logic [INDEX_WIDTH-1:0] rb_ex_index,
   input  logic                   rb_ex_taken,
   output logic                   tbl_rd_en,
   output logic [INDEX_WIDTH-1:0] tbl_rd_index,
   input  logic [CNT_WIDTH-1:0]   tbl_rd_data,
   output logic                   tbl_wr_en,
   output logic [INDEX_WIDTH-1:0] tbl_wr_index,
   output logic [CNT_WIDTH-1:0]   tbl_wr_data,
   output logic                   stall_req,
   output logic                   init_done,
   output logic                   idle
`ifdef BP_PHT_UPD_STATS_EN
   ,
   output logic [15:0]            drop_cnt,
   output logic [31:0]            op_cnt
`endif
);

   localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
   localparam logic [PTR_W:0] DEPTH_V = (PTR_W+1)'(QUEUE_DEPTH);
   localparam logic [INDEX_WIDTH-1:0] IDX_LAST = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_INIT_V = CNT_WIDTH'(CNT_INIT);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   // up=1 means +1, up=0 means -1
   typedef struct packed {
      logic [INDEX_WIDTH-1:0] index;
      logic                   up;
   } entry_t;

   state_t                 state;
   logic [INDEX_WIDTH-1:0] init_ptr;
   entry_t                 q [QUEUE_DEPTH];
   logic [PTR_W-1:0]       head, tail;
   logic [PTR_W:0]         count, free;
   logic                   w_valid, w_up;
   logic [INDEX_WIDTH-1:0] w_index;
   logic                   prev_wr_valid;
   logic [INDEX_WIDTH-1:0] prev_wr_index;
   logic [CNT_WIDTH-1:0]   prev_wr_data;
   logic                   pop;
   logic [2:0]             req_v;
   entry_t                 req_e [3];
   entry_t                 push_e [3];
   logic [1:0]             n_push;
   logic [CNT_WIDTH-1:0]   old_cnt, new_cnt;
`ifdef BP_PHT_UPD_STATS_EN
   logic [1:0]             n_drop;
   logic [16:0]            drop_sum;
`endif

   function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input logic [1:0] off);
      logic [PTR_W+1:0] sum;
      sum = (PTR_W+2)'(base) + (PTR_W+2)'(off);
      if (sum >= (PTR_W+2)'(QUEUE_DEPTH)) sum = sum - (PTR_W+2)'(QUEUE_DEPTH);
      return sum[PTR_W-1:0];
   endfunction

   // Compact the accepted requests oldest-first; the later sources lose when slots run out.
   always_comb begin
      pop      = (state == ST_RUN) && (count != '0);
      free     = DEPTH_V - count + (PTR_W+1)'(pop);
      req_v    = {upd_en, rb_id_en, rb_ex_en};
      req_e[0] = {rb_ex_index, ~rb_ex_taken};
      req_e[1] = {rb_id_index, ~rb_id_taken};
      req_e[2] = {upd_index, upd_taken};
      n_push   = '0;
`ifdef BP_PHT_UPD_STATS_EN
      n_drop   = '0;
`endif
      for (int unsigned k = 0; k < 3; k++) push_e[k] = '0;
      for (int unsigned k = 0; k < 3; k++) begin
         if (state == ST_RUN && req_v[k]) begin
            if ((PTR_W+1)'(n_push) < free) begin
               push_e[n_push] = req_e[k];
               n_push = n_push + 2'd1;
            end
`ifdef BP_PHT_UPD_STATS_EN
            else n_drop = n_drop + 2'd1;
`endif
         end
      end
   end

   // A read issued alongside a same-index write returns stale data, so use the last written value.
   always_comb begin
      old_cnt = (prev_wr_valid && prev_wr_index == w_index) ? prev_wr_data : tbl_rd_data;
      if (w_up) new_cnt = (old_cnt == CNT_MAX) ? old_cnt : old_cnt + CNT_WIDTH'(1);
      else      new_cnt = (old_cnt == '0)      ? old_cnt : old_cnt - CNT_WIDTH'(1);
      tbl_rd_en    = 1'b0;
      tbl_rd_index = '0;
      tbl_wr_en    = 1'b0;
      tbl_wr_index = '0;
      tbl_wr_data  = '0;
      if (!rst) begin
         if (state == ST_INIT) begin
            tbl_wr_en    = 1'b1;
            tbl_wr_index = init_ptr;
            tbl_wr_data  = CNT_INIT_V;
         end else if (w_valid) begin
            tbl_wr_en    = 1'b1;
            tbl_wr_index = w_index;
            tbl_wr_data  = new_cnt;
         end
         if (pop) begin
            tbl_rd_en    = 1'b1;
            tbl_rd_index = q[head].index;
         end
      end
      stall_req = rst || (state == ST_INIT) || ((DEPTH_V - count) < (PTR_W+1)'(3));
      init_done = !rst && (state == ST_RUN);
      idle      = !rst && (state == ST_RUN) && (count == '0) && !w_valid;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_INIT;
         init_ptr      <= '0;
         head          <= '0;
         tail          <= '0;
         count         <= '0;
         w_valid       <= 1'b0;
         w_up          <= 1'b0;
         w_index       <= '0;
         prev_wr_valid <= 1'b0;
         prev_wr_index <= '0;
         prev_wr_data  <= '0;
      end else begin
         case (state)
            ST_INIT: begin
               init_ptr <= init_ptr + INDEX_WIDTH'(1);
               if (init_ptr == IDX_LAST) state <= ST_RUN;
            end
            default: state <= ST_RUN;
         endcase
         tail    <= wrap_add(tail, n_push);
         if (pop) head <= wrap_add(head, 2'd1);
         count   <= count + (PTR_W+1)'(n_push) - (PTR_W+1)'(pop);
         w_valid <= pop;
         if (pop) begin
            w_index <= q[head].index;
            w_up    <= q[head].up;
         end
         prev_wr_valid <= tbl_wr_en;
         prev_wr_index <= tbl_wr_index;
         prev_wr_data  <= tbl_wr_data;
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned k = 0; k < 3; k++)
         if (!rst && k < 32'(n_push)) q[wrap_add(tail, 2'(k))] <= push_e[k];
   end

`ifdef BP_PHT_UPD_STATS_EN
   assign drop_sum = {1'b0, drop_cnt} + 17'(n_drop);

   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt <= '0;
         op_cnt   <= '0;
      end else begin
         drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
         if (state == ST_RUN && w_valid) op_cnt <= op_cnt + 32'd1;
      end
   end
`endif

endmodule
